// File: rtl/sync_fifo_ft.sv
// sync_fifo_ft: single-clock FIFO with first-word fall-through output.
// The head entry is visible on dout whenever empty is low. DEPTH_NBITS=0 gives
// a single-entry register; DEPTH_NBITS>=1 gives a 2^N-entry circular buffer.
//
// Ports:
//   clk     - rising-edge clock
//   rst     - asynchronous active-high reset
//   din     - write data
//   wr      - push din this cycle (dropped when full unless rd is also high)
//   rd      - pop head this cycle (ignored when empty)
//   dout    - head entry, combinational from storage
//   empty   - count == 0
//   full    - count == DEPTH
//   fullm1  - count >= DEPTH-1
//   emptyp2 - count < 2
//   count   - registered occupancy
//   ncount  - next-cycle occupancy (combinational)
module sync_fifo_ft #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEPTH_NBITS = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       din,
  input  logic                   wr,
  input  logic                   rd,
  output logic [WIDTH-1:0]       dout,
  output logic                   empty,
  output logic                   full,
  output logic                   fullm1,
  output logic                   emptyp2,
  output logic [DEPTH_NBITS:0]   count,
  output logic [DEPTH_NBITS:0]   ncount
);

  localparam int unsigned Depth = 1 << DEPTH_NBITS;
  localparam int unsigned CntW  = DEPTH_NBITS + 1;

  logic [CntW-1:0] count_q;
  logic            do_rd;
  logic            do_wr;

  // Flags come from the registered count only.
  assign empty   = (count_q == '0);
  assign full    = (32'(count_q) == Depth);
  assign fullm1  = (32'(count_q) >= Depth - 1);
  assign emptyp2 = (32'(count_q) < 32'd2);
  assign count   = count_q;

  assign do_rd = rd & ~empty;
  // A push into a full FIFO is accepted when a pop frees the slot on the same edge.
  assign do_wr = wr & (~full | rd);

  always_comb begin
    ncount = count_q;
    if (do_wr) ncount = ncount + CntW'(1);
    if (do_rd) ncount = ncount - CntW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= ncount;
    end
  end

  if (DEPTH_NBITS == 0) begin : g_single
    logic [WIDTH-1:0] mem_q;

    // Single entry: a simultaneous pop and push simply replaces the entry.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        mem_q <= '0;
      end else if (do_wr) begin
        mem_q <= din;
      end
    end

    assign dout = mem_q;
  end else begin : g_multi
    logic [WIDTH-1:0]       mem_q [Depth];
    logic [DEPTH_NBITS-1:0] rptr_q;
    logic [DEPTH_NBITS-1:0] wptr_q;

    // Pointers are exactly DEPTH_NBITS wide, so increments wrap modulo DEPTH.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rptr_q <= '0;
        wptr_q <= '0;
        for (int i = 0; i < int'(Depth); i++) begin
          mem_q[i] <= '0;
        end
      end else begin
        if (do_wr) begin
          mem_q[wptr_q] <= din;
          wptr_q        <= wptr_q + 1'b1;
        end
        if (do_rd) begin
          rptr_q <= rptr_q + 1'b1;
        end
      end
    end

    assign dout = mem_q[rptr_q];
  end

endmodule

// File: tb/tb_sync_fifo_ft.sv
module tb_sync_fifo_ft;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic [7:0] din2 = '0, dout2;
  logic       wr2 = 1'b0, rd2 = 1'b0;
  logic       empty2, full2, fullm12, emptyp22;
  logic [2:0] count2, ncount2;

  logic [7:0] din0 = '0, dout0;
  logic       wr0 = 1'b0, rd0 = 1'b0;
  logic       empty0, full0, fullm10, emptyp20;
  logic [0:0] count0, ncount0;

  int checks = 0;
  int errors = 0;

  // Reference queues: the FIFO contents, head at index 0.
  logic [7:0] q2[$];
  logic [7:0] q0[$];

  always #5 clk = ~clk;

  sync_fifo_ft #(.WIDTH(8), .DEPTH_NBITS(2)) u_fifo2 (
    .clk(clk), .rst(rst), .din(din2), .wr(wr2), .rd(rd2), .dout(dout2),
    .empty(empty2), .full(full2), .fullm1(fullm12), .emptyp2(emptyp22),
    .count(count2), .ncount(ncount2)
  );

  sync_fifo_ft #(.WIDTH(8), .DEPTH_NBITS(0)) u_fifo0 (
    .clk(clk), .rst(rst), .din(din0), .wr(wr0), .rd(rd0), .dout(dout0),
    .empty(empty0), .full(full0), .fullm1(fullm10), .emptyp2(emptyp20),
    .count(count0), .ncount(ncount0)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a pop happens if anything is held; a push if there is room or a pop frees it.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q2.delete();
      q0.delete();
    end else begin
      automatic bit dr2 = rd2 && q2.size() > 0;
      automatic bit dw2 = wr2 && (q2.size() < 4 || rd2);
      automatic bit dr0 = rd0 && q0.size() > 0;
      automatic bit dw0 = wr0 && (q0.size() < 1 || rd0);
      if (dr2) void'(q2.pop_front());
      if (dw2) q2.push_back(din2);
      if (dr0) void'(q0.pop_front());
      if (dw0) q0.push_back(din0);
    end
  end

  // Compare process: every low clock phase outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      automatic int s2 = q2.size();
      automatic int s0 = q0.size();
      automatic int n2 = s2 + int'(wr2 && (s2 < 4 || rd2)) - int'(rd2 && s2 > 0);
      automatic int n0 = s0 + int'(wr0 && (s0 < 1 || rd0)) - int'(rd0 && s0 > 0);
      chk("n2.count",   int'(count2),   s2);
      chk("n2.ncount",  int'(ncount2),  n2);
      chk("n2.empty",   int'(empty2),   int'(s2 == 0));
      chk("n2.full",    int'(full2),    int'(s2 == 4));
      chk("n2.fullm1",  int'(fullm12),  int'(s2 >= 3));
      chk("n2.emptyp2", int'(emptyp22), int'(s2 < 2));
      if (s2 > 0) chk("n2.dout", int'(dout2), int'(q2[0]));
      chk("n0.count",   int'(count0),   s0);
      chk("n0.ncount",  int'(ncount0),  n0);
      chk("n0.empty",   int'(empty0),   int'(s0 == 0));
      chk("n0.full",    int'(full0),    int'(s0 == 1));
      chk("n0.fullm1",  int'(fullm10),  1);
      chk("n0.emptyp2", int'(emptyp20), 1);
      if (s0 > 0) chk("n0.dout", int'(dout0), int'(q0[0]));
    end
  end

  // Apply one cycle of inputs, return 1 time unit after the edge that consumed them.
  task automatic drive(input bit w2, input bit r2, input logic [7:0] d2,
                       input bit w0, input bit r0, input logic [7:0] d0);
    wr2 = w2; rd2 = r2; din2 = d2;
    wr0 = w0; rd0 = r0; din0 = d0;
    @(posedge clk);
    #1;
    wr2 = 1'b0; rd2 = 1'b0; wr0 = 1'b0; rd0 = 1'b0;
  endtask

  initial begin
    int pushes, pops;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.empty",   int'(empty2),   1);
    chk("rst.full",    int'(full2),    0);
    chk("rst.count",   int'(count2),   0);
    chk("rst.fullm1",  int'(fullm12),  0);
    chk("rst.emptyp2", int'(emptyp22), 1);
    chk("rst.dout",    int'(dout2),    0);
    chk("rst.n0.fullm1", int'(fullm10), 1);
    chk("rst.n0.empty",  int'(empty0),  1);
    rst = 1'b0;

    // Fill the 4-entry FIFO.
    drive(1, 0, 8'h11, 0, 0, 8'h00);
    chk("fill.dout1",  int'(dout2),  8'h11);
    drive(1, 0, 8'h22, 0, 0, 8'h00);
    drive(1, 0, 8'h33, 0, 0, 8'h00);
    chk("fill.count3",  int'(count2),  3);
    chk("fill.fullm1",  int'(fullm12), 1);
    chk("fill.notfull", int'(full2),   0);
    drive(1, 0, 8'h44, 0, 0, 8'h00);
    chk("fill.full",   int'(full2),  1);
    drive(1, 0, 8'h99, 0, 0, 8'h00);
    chk("ovf.count",   int'(count2), 4);
    chk("ovf.dout",    int'(dout2),  8'h11);

    // Pop and push together while full.
    drive(1, 1, 8'h55, 0, 0, 8'h00);
    chk("rdwr.count",  int'(count2), 4);
    chk("rdwr.dout",   int'(dout2),  8'h22);
    chk("rdwr.full",   int'(full2),  1);
    chk("drain.0", int'(dout2), 8'h22);
    drive(0, 1, 8'h00, 0, 0, 8'h00);
    chk("drain.1", int'(dout2), 8'h33);
    drive(0, 1, 8'h00, 0, 0, 8'h00);
    chk("drain.2", int'(dout2), 8'h44);
    drive(0, 1, 8'h00, 0, 0, 8'h00);
    chk("drain.3", int'(dout2), 8'h55);
    drive(0, 1, 8'h00, 0, 0, 8'h00);
    chk("drain.empty", int'(empty2), 1);

    // Empty boundaries.
    drive(0, 1, 8'h00, 0, 0, 8'h00);
    chk("rdempty.count", int'(count2), 0);
    drive(1, 1, 8'hA5, 0, 0, 8'h00);
    chk("rdwrempty.count", int'(count2), 1);
    chk("rdwrempty.dout",  int'(dout2),  8'hA5);
    drive(0, 1, 8'h00, 0, 0, 8'h00);

    // Single-entry form.
    drive(0, 0, 8'h00, 1, 0, 8'h7E);
    chk("n0.full.w",  int'(full0), 1);
    chk("n0.dout.w",  int'(dout0), 8'h7E);
    drive(0, 0, 8'h00, 1, 1, 8'h81);
    chk("n0.dout.rw", int'(dout0), 8'h81);
    chk("n0.full.rw", int'(full0), 1);
    drive(0, 0, 8'h00, 0, 1, 8'h00);
    chk("n0.empty.r", int'(empty0), 1);

    // Random interleave of 10 accepted pushes and 10 accepted pops, crossing pointer wrap.
    pushes = 0;
    pops   = 0;
    for (int cyc = 0; cyc < 400 && (pushes < 10 || pops < 10); cyc++) begin
      automatic bit w = (pushes < 10) && ($urandom_range(0, 1) == 1);
      automatic bit r = (pops < 10) && ($urandom_range(0, 1) == 1);
      automatic int s = q2.size();
      if (r && s > 0) pops++;
      if (w && (s < 4 || r)) pushes++;
      drive(w, r, 8'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            8'($urandom));
    end
    chk("rand.pushes", pushes, 10);
    chk("rand.pops",   pops,   10);

    // Reset in the middle of traffic takes effect without a clock edge.
    drive(1, 0, 8'h12, 1, 0, 8'h34);
    drive(1, 0, 8'h56, 0, 0, 8'h00);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst.empty",  int'(empty2), 1);
    chk("midrst.count",  int'(count2), 0);
    chk("midrst.dout",   int'(dout2),  0);
    chk("midrst.n0.empty", int'(empty0), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1, 0, 8'h3C, 0, 0, 8'h00);
    chk("postrst.dout", int'(dout2), 8'h3C);
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
